// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter sharing one vga_adapter plot port among 3 requesters; pixel out 1 cycle after handshake.
// Backpressure: req_ready only to the owner in OWN; optional PLOT_CLIP_EN discards off-screen pixels and pulses clipped.
module vga_plot_arbiter #(
  parameter int XMAX = 159,
  parameter int YMAX = 119
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic [2:0]  req_valid,
  input  logic [2:0]  req_lock,
  input  logic [23:0] req_x,
  input  logic [20:0] req_y,
  input  logic [8:0]  req_colour,
  output logic [2:0]  req_ready,
  output logic [2:0]  grant,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        clipped,
  output logic        busy
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_OWN  = 1'b1;

`ifdef PLOT_CLIP_EN
  localparam logic CLIP_EN = 1'b1;
`else
  localparam logic CLIP_EN = 1'b0;
`endif

  localparam logic [7:0] XMAX_L = 8'(XMAX);
  localparam logic [6:0] YMAX_L = 7'(YMAX);

  logic       state;
  logic [1:0] last;
  logic [2:0] win;
  logic [1:0] own_idx;
  logic [7:0] sel_x;
  logic [6:0] sel_y;
  logic [2:0] sel_colour;
  logic       hs;
  logic       lock_g;
  logic       clip_hit;

  // Search order starts just after the last owner and wraps.
  always_comb begin
    win = 3'b000;
    case (last)
      2'd0: begin
        if (req_valid[1])      win = 3'b010;
        else if (req_valid[2]) win = 3'b100;
        else if (req_valid[0]) win = 3'b001;
      end
      2'd1: begin
        if (req_valid[2])      win = 3'b100;
        else if (req_valid[0]) win = 3'b001;
        else if (req_valid[1]) win = 3'b010;
      end
      default: begin
        if (req_valid[0])      win = 3'b001;
        else if (req_valid[1]) win = 3'b010;
        else if (req_valid[2]) win = 3'b100;
      end
    endcase
  end

  always_comb begin
    own_idx    = 2'd0;
    sel_x      = req_x[7:0];
    sel_y      = req_y[6:0];
    sel_colour = req_colour[2:0];
    if (grant[1]) begin
      own_idx    = 2'd1;
      sel_x      = req_x[15:8];
      sel_y      = req_y[13:7];
      sel_colour = req_colour[5:3];
    end else if (grant[2]) begin
      own_idx    = 2'd2;
      sel_x      = req_x[23:16];
      sel_y      = req_y[20:14];
      sel_colour = req_colour[8:6];
    end
  end

  assign hs       = (state == ST_OWN) && ((grant & req_valid) != 3'b000);
  assign lock_g   = (grant & req_lock) != 3'b000;
  assign clip_hit = CLIP_EN && ((sel_x > XMAX_L) || (sel_y > YMAX_L));

  assign busy      = (state == ST_OWN);
  assign req_ready = (state == ST_OWN) ? grant : 3'b000;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      grant   <= 3'b000;
      last    <= 2'd2;
      x       <= 8'd0;
      y       <= 7'd0;
      colour  <= 3'd0;
      plot    <= 1'b0;
      clipped <= 1'b0;
    end else begin
      plot    <= 1'b0;
      clipped <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid != 3'b000) begin
            grant <= win;
            state <= ST_OWN;
          end
        end
        default: begin
          if (hs) begin
            if (clip_hit) begin
              clipped <= 1'b1;
            end else begin
              plot   <= 1'b1;
              x      <= sel_x;
              y      <= sel_y;
              colour <= sel_colour;
            end
          end
          // Unlocked owner gives up the port whether or not it sent a pixel.
          if (!lock_g) begin
            grant <= 3'b000;
            state <= ST_IDLE;
            last  <= own_idx;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/vga_plot_arbiter.md
VGA_PLOT_ARBITER -- requirements
Module: vga_plot_arbiter

Interface
REQ-001 Parameter XMAX, default 159, largest legal x coordinate (160x120 mode).
REQ-002 Parameter YMAX, default 119, largest legal y coordinate.
REQ-003 CLOCK_50  in  1  sole clock; all state updates on rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  3  per-requester pixel-valid (bit 0 = background, 1 = sprite, 2 = eraser).
REQ-006 req_lock  in  3  per-requester hold-grant flag, sampled at each handshake.
REQ-007 req_x  in  24  packed x, requester i at bits [8i+7:8i].
REQ-008 req_y  in  21  packed y, requester i at bits [7i+6:7i].
REQ-009 req_colour  in  9  packed colour, requester i at bits [3i+2:3i].
REQ-010 req_ready  out  3  per-requester ready; equals grant in state OWN, else 0.
REQ-011 grant  out  3  registered one-hot owner, 0 when idle.
REQ-012 x  out  8, y  out  7, colour  out  3  registered pixel to vga_adapter.
REQ-013 plot  out  1  registered write strobe to vga_adapter plot input.
REQ-014 clipped  out  1  one-cycle pulse when an accepted pixel is discarded.
REQ-015 busy  out  1  high whenever state is OWN.

Function
REQ-016 FSM has two states: IDLE, OWN.
REQ-017 IDLE: if any req_valid bit is set, grant SHALL load one-hot winner and state SHALL go to OWN on the next edge; otherwise remain IDLE.
REQ-018 Winner is round-robin: search starts at index (last+1) mod 3, wraps, first set req_valid wins.
REQ-019 last SHALL update to the owner index when the grant is released.
REQ-020 Handshake on requester g occurs in a cycle where state is OWN, grant[g]=1 and req_valid[g]=1.
REQ-021 On handshake, x/y/colour SHALL register that requester's fields and plot SHALL be 1 in the following cycle only (latency 1).
REQ-022 plot SHALL be 0 in every cycle not immediately following a handshake; exactly one plot pulse per accepted, non-clipped pixel.
REQ-023 Handshake with req_lock[g]=1: remain OWN, grant unchanged; back-to-back handshakes give 1 pixel/cycle.
REQ-024 Handshake with req_lock[g]=0: release on the same edge (grant<=0, state<=IDLE); unlocked streams give 1 pixel per 2 cycles.
REQ-025 In OWN with req_valid[g]=0 and req_lock[g]=1: hold grant, no plot.
REQ-026 In OWN with req_valid[g]=0 and req_lock[g]=0: release without plot.
REQ-027 A requester re-raising valid in the release cycle SHALL wait through one IDLE cycle and arbitrate normally.
REQ-028 Inputs of non-granted requesters SHALL never affect x, y, colour or plot.
REQ-029 x, y, colour SHALL hold their last value when plot is 0.

Reset
REQ-030 resetn low SHALL immediately force: state IDLE, grant 0, req_ready 0, plot 0, clipped 0, busy 0, x 0, y 0, colour 0, last 2 (requester 0 highest priority first).
REQ-031 Reset mid-stream SHALL drop any in-flight pixel; no plot pulse after reset release until a new handshake.

Configuration
REQ-032 Macro PLOT_CLIP_EN: when defined, a handshake with x>XMAX or y>YMAX SHALL complete normally but produce plot=0 and clipped=1 in the following cycle.
REQ-033 Without PLOT_CLIP_EN, coordinates pass unchecked, plot follows REQ-021, and clipped is tied to 0.

Verification
REQ-034 Reset, then req_valid=3'b111, lock=0 -> grants in order 001,010,100,001 with one IDLE cycle between each.
REQ-035 Requester 1 valid+lock, 5 pixels (x=10..14, y=20, colour=3'b101) -> plot high 5 consecutive cycles, one cycle after each handshake, grant stays 010.
REQ-036 Requester 2 locked, valid drops 3 cycles then returns -> grant held, plot 0 for those 3 cycles, no other requester served.
REQ-037 PLOT_CLIP_EN defined, pixel x=160,y=5 -> plot 0, clipped 1 one cycle later; undefined -> plot 1 with x=160.
REQ-038 resetn pulsed low during locked stream of requester 0 -> all outputs 0 asynchronously; after release, requester 0 wins first if valid.
